pool_ctrl: RTL and testbench
============================

POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter THRESH, default 8'd2: pooling threshold; a sample is "high" when strictly greater than THRESH.
REQ-002 Parameter FRAME_WINDOWS, default 16, range 1..255: number of 4-sample windows per frame.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle frame start request; honoured only in IDLE.
REQ-006 in_valid  input  1  convolution result valid.
REQ-007 in_data  input  8  unsigned convolution result.
REQ-008 in_ready  output  1  controller accepts in_data this cycle.
REQ-009 out_valid  output  1  pooled window available.
REQ-010 out_pixels  output  [3:0][7:0]  pooled window; slot 0 holds the oldest sample.
REQ-011 out_ready  input  1  downstream accepts out_pixels.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Function
REQ-014 FSM states: IDLE, FILL, EMIT, DONE; transfers are in_valid&&in_ready and out_valid&&out_ready.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> FILL, clearing slot index (2b) and window counter (8b).
REQ-016 FILL: in_ready=1; each input transfer stores (in_data>THRESH ? 8'h01 : 8'hFF) into out_pixels[idx], then idx+1.
REQ-017 Input transfer with idx==3: idx wraps to 0 and state -> EMIT; out_valid rises the following cycle (one-cycle latency).
REQ-018 EMIT: out_valid=1, in_ready=0; out_pixels held stable until the output transfer; out_valid never drops without a transfer.
REQ-019 Output transfer with window counter == FRAME_WINDOWS-1 -> DONE; otherwise window counter+1 and -> FILL.
REQ-020 DONE: lasts exactly one cycle; frame_done=1, then -> IDLE.
REQ-021 start is ignored outside IDLE; in_valid is ignored outside FILL.
REQ-022 in_data == THRESH maps to 8'hFF (the comparison is strict).
REQ-023 Threshold comparison is unsigned, 8-bit; no saturation or rounding.

Reset
REQ-024 rst asserted: state=IDLE, idx=0, window counter=0, out_pixels=0, out_valid=0, in_ready=0, busy=0, frame_done=0, asynchronously.
REQ-025 rst mid-frame discards the partial window; no out_valid or frame_done occurs for the aborted frame.

Configuration
REQ-026 With POOL_CTRL_STATS_EN defined, output win_count[7:0] equals the number of windows accepted in the current frame; it is reset by rst and by start in IDLE.
REQ-027 With POOL_CTRL_STATS_EN defined, win_count holds its final value after DONE until the next start.
REQ-028 Without POOL_CTRL_STATS_EN, port win_count and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package pool_pkg holds the state enum typedef pool_state_t, the POOL_WIN=4 constant and the 8'h01 and 8'hFF pooled-value constants.
REQ-030 A single sub-module, pool_thresh (combinational compare-and-map, THRESH parameter), is instantiated once.

Verification
REQ-031 Reset, start, 4 inputs 3,2,0,255 with out_ready=1 -> out_pixels {[0]=01,[1]=FF,[2]=FF,[3]=01}; out_valid rises 1 cycle after the 4th transfer.
REQ-032 out_ready held low 5 cycles in EMIT -> out_valid stays 1, out_pixels stable, in_ready=0 throughout.
REQ-033 FRAME_WINDOWS=2, 8 inputs -> exactly 2 output transfers, then frame_done pulses for 1 cycle, then busy=0.
REQ-034 rst asserted after 2 of 4 inputs, then a new start and 4 inputs of 9 -> single window of all 01, no stale data.
REQ-035 start pulsed during FILL and EMIT -> ignored; in_valid in IDLE -> in_ready=0, nothing captured.
REQ-036 With POOL_CTRL_STATS_EN defined and FRAME_WINDOWS=3 -> win_count steps 0,1,2,3 and holds 3 after frame_done.

Source files
------------

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared state type and constants for the pooling controller
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } pool_state_t;

  localparam int         POOL_WIN  = 4;
  localparam logic [7:0] POOL_HIGH = 8'h01;
  localparam logic [7:0] POOL_LOW  = 8'hFF;

endpackage

// File: rtl/pool_ctrl_thresh.sv
// rtl/pool_ctrl_thresh.sv - combinational threshold compare-and-map for one sample
module pool_thresh
  import pool_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd2
) (
  input  logic [7:0] sample,
  output logic [7:0] pooled
);

  // Strict unsigned compare: a sample equal to THRESH counts as low.
  assign pooled = (sample > THRESH) ? POOL_HIGH : POOL_LOW;

endmodule

// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - 4-sample window pooling controller, optional win_count via POOL_CTRL_STATS_EN
module pool_ctrl
  import pool_pkg::*;
#(
  parameter logic [7:0] THRESH        = 8'd2,
  parameter int         FRAME_WINDOWS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [3:0][7:0] out_pixels,
  input  logic            out_ready,
  output logic            busy,
  output logic            frame_done
`ifdef POOL_CTRL_STATS_EN
  ,
  output logic [7:0]      win_count
`endif
);

  localparam int         IDX_W    = $clog2(POOL_WIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_WIN - 1);
  localparam logic [7:0] LAST_WIN = 8'(FRAME_WINDOWS - 1);

  pool_state_t      state;
  pool_state_t      next_state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       win_cnt;
  logic [7:0]       pooled;
  logic             in_xfer;
  logic             out_xfer;

  // Transfers are decoded from state directly so they do not loop through the output logic.
  assign in_xfer  = in_valid  && (state == FILL);
  assign out_xfer = out_ready && (state == EMIT);

  pool_thresh #(
    .THRESH (THRESH)
  ) u_thresh (
    .sample (in_data),
    .pooled (pooled)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_xfer && (idx == LAST_IDX)) begin
          next_state = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_xfer) begin
          next_state = (win_cnt == LAST_WIN) ? DONE : FILL;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Window capture, slot index and per-frame window counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      win_cnt    <= '0;
      out_pixels <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            win_cnt <= '0;
          end
        end
        FILL: begin
          if (in_xfer) begin
            out_pixels[idx] <= pooled;
            idx             <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (out_xfer && (win_cnt != LAST_WIN)) begin
            win_cnt <= win_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef POOL_CTRL_STATS_EN
  // Accepted-window count for the current frame; holds after DONE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count <= 8'd0;
    end else if ((state == IDLE) && start) begin
      win_count <= 8'd0;
    end else if (out_xfer) begin
      win_count <= win_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// tb/tb_pool_ctrl.sv - scoreboard bench for pool_ctrl, covers POOL_CTRL_STATS_EN when defined
module tb_pool_ctrl;

`ifdef POOL_CTRL_STATS_EN
  localparam int FW = 3;
`else
  localparam int FW = 2;
`endif

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            start     = 1'b0;
  logic            in_valid  = 1'b0;
  logic [7:0]      in_data   = 8'd0;
  logic            out_ready = 1'b1;
  logic            in_ready;
  logic            out_valid;
  logic [3:0][7:0] out_pixels;
  logic            busy;
  logic            frame_done;
`ifdef POOL_CTRL_STATS_EN
  logic [7:0]      win_count;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  // Samples packed {s3,s2,s1,s0}, s0 sent first; expected packed {slot3..slot0}.
  logic [31:0] win_samp [4] = '{32'hFF000203, 32'hC8020301, 32'h09090909, 32'h00030202};
  logic [31:0] win_exp  [4] = '{32'h01FFFF01, 32'h01FF01FF, 32'h01010101, 32'hFF01FFFF};

  pool_ctrl #(
    .THRESH        (8'd2),
    .FRAME_WINDOWS (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pixels (out_pixels),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef POOL_CTRL_STATS_EN
    ,
    .win_count  (win_count)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: every accepted window is matched against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfers++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h, required no output", out_pixels);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_pixels !== mon_exp) begin
          errors++;
          $display("FAIL out_pixels: got %h, required %h", out_pixels, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put(input logic [7:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("put_ready", in_ready, 1'b1);
    chk1("fill_no_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_window(input int w, input int hold, input bit glitch);
    exp_q.push_back(win_exp[w]);
    for (int i = 0; i < 4; i++) begin
      if (glitch && i == 2) begin
        do_start();
      end
      put(win_samp[w][8*i +: 8]);
    end
    chk1("out_valid_latency", out_valid, 1'b1);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
        start = (k == 2);
        @(negedge clk);
        chk1("hold_valid", out_valid, 1'b1);
        chk1("hold_in_ready", in_ready, 1'b0);
        chk32("hold_pixels", out_pixels, win_exp[w]);
        @(posedge clk);
        #1;
      end
      start     = 1'b0;
      out_ready = 1'b1;
    end
    tick();
  endtask

  task automatic run_frame(input int first_w, input bit special);
    do_start();
    chk1("start_busy", busy, 1'b1);
    chk1("start_in_ready", in_ready, 1'b1);
`ifdef POOL_CTRL_STATS_EN
    chk32("win_count_start", 32'(win_count), 32'd0);
`endif
    for (int w = 0; w < FW; w++) begin
      do_window((first_w + w) % 4, (special && w == 1) ? 5 : 0, special && w == 0);
`ifdef POOL_CTRL_STATS_EN
      chk32("win_count_step", 32'(win_count), 32'(w + 1));
`endif
      if (w < FW - 1) begin
        chk1("frame_done_early", frame_done, 1'b0);
      end
    end
    chk1("frame_done_pulse", frame_done, 1'b1);
    chk1("done_busy", busy, 1'b1);
    tick();
    chk1("frame_done_end", frame_done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_in_ready", in_ready, 1'b0);
`ifdef POOL_CTRL_STATS_EN
    chk32("win_count_final", 32'(win_count), 32'(FW));
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk32("rst_pixels", out_pixels, 32'h0);
`ifdef POOL_CTRL_STATS_EN
    chk32("rst_win_count", 32'(win_count), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // in_valid while idle must not be accepted.
    in_valid = 1'b1;
    in_data  = 8'd200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("idle_in_ready_hold", in_ready, 1'b0);
      chk1("idle_out_valid", out_valid, 1'b0);
      chk1("idle_busy_hold", busy, 1'b0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Frame with start pulses in FILL and EMIT plus output backpressure.
    run_frame(0, 1'b1);
    tick();
    tick();
    chk1("idle_after_frame", busy, 1'b0);
`ifdef POOL_CTRL_STATS_EN
    chk32("win_count_hold", 32'(win_count), 32'(FW));
`endif

    // Abort a frame mid-window with an asynchronous reset.
    do_start();
    put(8'd3);
    put(8'd5);
    rst = 1'b1;
    #1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b0);
    chk1("abort_frame_done", frame_done, 1'b0);
    chk32("abort_pixels", out_pixels, 32'h0);
`ifdef POOL_CTRL_STATS_EN
    chk32("abort_win_count", 32'(win_count), 32'd0);
`endif
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("post_abort_valid", out_valid, 1'b0);
      chk1("post_abort_done", frame_done, 1'b0);
      @(posedge clk);
      #1;
    end

    // Clean frame after the abort.
    run_frame(2, 1'b0);
    tick();

    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk32("out_transfer_count", 32'(xfers), 32'(2 * FW));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
